// File: rtl/shift_reg_sequencer_if.sv
// Handshake and shift-register bus for shift_reg_sequencer.
// master: host/register side (drives in_valid, in_data, out_ready, sr_so).
// slave:  the sequencer itself.
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sr_si;
    logic             sr_shift_en;
    logic             sr_so;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready, sr_so,
        input  in_ready, sr_si, sr_shift_en, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready, sr_so,
        output in_ready, sr_si, sr_shift_en, out_valid, out_data
    );
endinterface

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: loads a parallel word into a WIDTH-bit serial shift
// register over exactly WIDTH enabled cycles while capturing the word that
// was previously held in it, then offers that old word on a valid/ready port.
// Default bit order is LSB-first; defining SR_SEQ_MSB_FIRST_EN switches the
// serial wire order to MSB-first with identical cycle timing.
module shift_reg_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    shift_reg_sequencer_if.slave bus,
    output logic                 busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             tx_bit;

`ifdef SR_SEQ_MSB_FIRST_EN
    assign tx_bit = tx_q[WIDTH-1];
`else
    assign tx_bit = tx_q[0];
`endif

    // Outputs are pure decodes of registered state, so nothing on the
    // register side depends combinationally on in_valid.
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.sr_shift_en = (state_q == SHIFT);
    assign bus.sr_si       = (state_q == SHIFT) & tx_bit;
    assign bus.out_valid   = (state_q == HOLD);
    assign bus.out_data    = rx_q;
    assign busy            = (state_q != IDLE);

    // Next-state logic: accept a word in IDLE, shift WIDTH times, then hold
    // the captured word until the consumer takes it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    tx_d    = bus.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
`ifdef SR_SEQ_MSB_FIRST_EN
                tx_d = tx_q << 1;
                rx_d = {rx_q[WIDTH-2:0], bus.sr_so};
`else
                tx_d = tx_q >> 1;
                rx_d = {bus.sr_so, rx_q[WIDTH-1:1]};
`endif
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; an asynchronous reset aborts any transfer in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Testbench for shift_reg_sequencer: a behavioural model of the external
// shift register sits on the serial side, a queue holds the word each
// transfer should return, and directed steps exercise reset, back-pressure,
// ignored in_valid, a mid-transfer reset and a few random words.
module tb_shift_reg_sequencer;
    localparam int WIDTH = 8;

    logic CLK;
    logic RST_N;
    logic busy;

    shift_reg_sequencer_if #(.WIDTH(WIDTH)) bus ();

    shift_reg_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus),
        .busy (busy)
    );

    int compared   = 0;
    int mismatched = 0;
    int shift_count = 0;

    logic [WIDTH-1:0] sr_reg;
    logic             preload_en;
    logic [WIDTH-1:0] preload_val;
    logic [WIDTH-1:0] exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // The external register: SI enters at the MSB, SO leaves from bit 0.
    always @(posedge CLK) begin
        if (preload_en) begin
            sr_reg <= preload_val;
        end else if (bus.sr_shift_en) begin
            sr_reg <= {bus.sr_si, sr_reg[WIDTH-1:1]};
        end
    end

    // Count every enabled shift edge.
    always @(posedge CLK) begin
        if (bus.sr_shift_en) begin
            shift_count <= shift_count + 1;
        end
    end

    assign bus.sr_so = sr_reg[0];

    function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // Register contents after a transfer of word w.
    function automatic logic [WIDTH-1:0] reg_after(input logic [WIDTH-1:0] w);
`ifdef SR_SEQ_MSB_FIRST_EN
        return rev(w);
`else
        return w;
`endif
    endfunction

    // Word returned on out_data when the register held r before the transfer.
    function automatic logic [WIDTH-1:0] out_from(input logic [WIDTH-1:0] r);
`ifdef SR_SEQ_MSB_FIRST_EN
        return rev(r);
`else
        return r;
`endif
    endfunction

    // Serial bit presented on sr_si during shift cycle i.
    function automatic logic si_bit(input logic [WIDTH-1:0] w, input int i);
`ifdef SR_SEQ_MSB_FIRST_EN
        return w[WIDTH-1-i];
`else
        return w[i];
`endif
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic preload(input logic [WIDTH-1:0] v);
        preload_en  = 1'b1;
        preload_val = v;
        next_cycle();
        preload_en  = 1'b0;
    endtask

    // One full transfer; entered and left on a negedge with the DUT idle.
    task automatic apply_stimulus(input logic [WIDTH-1:0] word, input int hold_cycles,
                                  input bit noisy);
        int               start_count;
        logic [WIDTH-1:0] exp_word;
        start_count   = shift_count;
        bus.in_valid  = 1'b1;
        bus.in_data   = word;
        bus.out_ready = 1'b0;
        check_bit("in_ready_idle", bus.in_ready, 1'b1);
        exp_q.push_back(out_from(sr_reg));
        next_cycle();
        if (noisy) begin
            bus.in_data = WIDTH'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
        check_bit("in_ready_shift", bus.in_ready, 1'b0);
        check_bit("busy_shift", busy, 1'b1);
        for (int i = 0; i < WIDTH; i++) begin
            check_bit("shift_en", bus.sr_shift_en, 1'b1);
            check_bit("sr_si", bus.sr_si, si_bit(word, i));
            if (noisy) bus.in_data = WIDTH'($urandom);
            next_cycle();
        end
        check_int("shift_count", shift_count - start_count, WIDTH);
        check_word("reg_after", sr_reg, reg_after(word));
        for (int c = 0; c < hold_cycles; c++) begin
            check_bit("out_valid_hold", bus.out_valid, 1'b1);
            check_word("out_data_hold", bus.out_data, exp_q[0]);
            check_bit("in_ready_hold", bus.in_ready, 1'b0);
            check_bit("shift_en_hold", bus.sr_shift_en, 1'b0);
            next_cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_bit("out_valid", bus.out_valid, 1'b1);
        exp_word = exp_q.pop_front();
        check_word("out_data", bus.out_data, exp_word);
        next_cycle();
        bus.out_ready = 1'b0;
        check_bit("in_ready_after", bus.in_ready, 1'b1);
        check_bit("out_valid_after", bus.out_valid, 1'b0);
        check_bit("busy_after", busy, 1'b0);
        check_int("no_extra_shift", shift_count - start_count, WIDTH);
    endtask

    // Bound the whole run in case the DUT stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int start_count;
        RST_N         = 1'b0;
        preload_en    = 1'b0;
        preload_val   = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge CLK);
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_shift_en", bus.sr_shift_en, 1'b0);
        check_bit("rst_sr_si", bus.sr_si, 1'b0);
        check_word("rst_out_data", bus.out_data, '0);
        RST_N = 1'b1;
        next_cycle();

        $display("[TB] transfer A5 into cleared register");
        preload(8'h00);
        apply_stimulus(8'hA5, 0, 1'b0);

        $display("[TB] transfer 3C with 5 cycles of back-pressure");
        apply_stimulus(8'h3C, 5, 1'b0);

        $display("[TB] transfer 5A with in_valid held throughout");
        apply_stimulus(8'h5A, 2, 1'b1);

        $display("[TB] reset in the middle of a transfer");
        start_count  = shift_count;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC3;
        next_cycle();
        bus.in_valid = 1'b0;
        repeat (4) next_cycle();
        RST_N = 1'b0;
        #1;
        check_bit("abort_in_ready", bus.in_ready, 1'b1);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_shift_en", bus.sr_shift_en, 1'b0);
        check_bit("abort_out_valid", bus.out_valid, 1'b0);
        check_word("abort_out_data", bus.out_data, '0);
        next_cycle();
        RST_N = 1'b1;
        repeat (3) begin
            next_cycle();
            check_bit("abort_no_valid", bus.out_valid, 1'b0);
        end
        check_int("abort_shifts", shift_count - start_count, 4);

        $display("[TB] transfer 01 into register holding 80");
        preload(8'h80);
        apply_stimulus(8'h01, 0, 1'b0);

        $display("[TB] random transfers");
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(WIDTH'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        check_int("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
